// File: rtl/debounce_edge_detector.sv
// Debounce filter with registered level and one-cycle rise/fall pulses.
// Optional press counter enabled by defining DEBOUNCE_PRESS_COUNT_EN.
module debounce_edge_detector #(
  parameter int STABLE_CYCLES = 16,
  parameter int PRESS_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic               level,
  output logic               rise,
  output logic               fall
`ifdef DEBOUNCE_PRESS_COUNT_EN
  ,
  output logic [PRESS_W-1:0] press_count
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || PRESS_W < 1) begin : g_param_check
    $error("debounce_edge_detector: illegal parameter value");
  end

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  // The edge on which a new high level is accepted; shared by the FSM and press counter.
  logic w_accept_rise;
  assign w_accept_rise = (r_state == CHK_HI) && din && (r_cnt == CNT_LAST);

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (din) begin
            r_state <= CHK_HI;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        CHK_HI: begin
          if (!din) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (w_accept_rise) begin
            r_state <= STABLE_HI;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!din) begin
            r_state <= CHK_LO;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        CHK_LO: begin
          if (din) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef DEBOUNCE_PRESS_COUNT_EN
  logic [PRESS_W-1:0] r_press_count;

  // Wraps naturally at 2^PRESS_W; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_press_count <= '0;
    end else if (w_accept_rise) begin
      r_press_count <= r_press_count + PRESS_W'(1);
    end
  end

  assign press_count = r_press_count;
`endif

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Self-checking bench for debounce_edge_detector (STABLE_CYCLES=4, PRESS_W=2).
// Scenario tasks compare against a streak-counting reference model.
module tb_debounce_edge_detector;

  localparam int N  = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic level;
  logic rise;
  logic fall;
`ifdef DEBOUNCE_PRESS_COUNT_EN
  logic [PW-1:0] press_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_edge_detector #(
    .STABLE_CYCLES(N),
    .PRESS_W      (PW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .level      (level),
    .rise       (rise),
    .fall       (fall)
`ifdef DEBOUNCE_PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  // Reference model: the level flips once N consecutive samples disagree with it.
  bit          m_level;
  bit          m_rise;
  bit          m_fall;
  int          m_streak;
  int unsigned m_presses;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_level = 0; m_rise = 0; m_fall = 0; m_streak = 0; m_presses = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (din != m_level) begin
        m_streak++;
        if (m_streak == N) begin
          m_level = !m_level;
          if (m_level) begin
            m_rise = 1;
            m_presses++;
          end else begin
            m_fall = 1;
          end
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
  end

  task automatic tick(input logic d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic d);
    din   = d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    din   = 1'b0;
    reset = 1'b1;
    #2;
    n_checks++;
    if ({level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_assert: got lvl/rise/fall=%b expected 000", {level, rise, fall});
    end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    n_checks++;
    if (press_count !== '0) begin
      n_fail++;
      $display("FAIL reset_press_count: got %0d expected 0", press_count);
    end
`endif
  endtask

  task automatic test_idle_low();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      n_checks++;
      if ({level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_low[%0d]: got lvl/rise/fall=%b expected 000", i, {level, rise, fall});
      end
    end
  endtask

  task automatic test_glitch_then_rise();
    logic [2:0] exp;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_checks++;
      if ({level, rise, fall} !== 3'b000) begin
        n_fail++;
        $display("FAIL short_high[%0d]: got lvl/rise/fall=%b expected 000", i, {level, rise, fall});
      end
    end
    tick(1'b0);
    n_checks++;
    if ({level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch_drop: got lvl/rise/fall=%b expected 000", {level, rise, fall});
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      exp = (i < 3) ? 3'b000 : (i == 3) ? 3'b110 : 3'b100;
      n_checks++;
      if ({level, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL qualify_rise[%0d]: got lvl/rise/fall=%b expected %b", i, {level, rise, fall}, exp);
      end
    end
  endtask

  task automatic test_chatter_fall();
    logic [4:0] pattern = 5'b01001;  // din sequence 0,1,0,0,1 (MSB first)
    logic [2:0] exp;
    for (int i = 4; i >= 0; i--) begin
      tick(pattern[i]);
      n_checks++;
      if ({level, rise, fall} !== 3'b100) begin
        n_fail++;
        $display("FAIL chatter[%0d]: got lvl/rise/fall=%b expected 100", 4 - i, {level, rise, fall});
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      exp = (i < 3) ? 3'b100 : (i == 3) ? 3'b001 : 3'b000;
      n_checks++;
      if ({level, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL qualify_fall[%0d]: got lvl/rise/fall=%b expected %b", i, {level, rise, fall}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    logic [2:0] exp;
    tick(1'b1);
    tick(1'b1);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_chk_hi: got lvl/rise/fall=%b expected 000", {level, rise, fall});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      exp = (i < 3) ? 3'b000 : (i == 3) ? 3'b110 : 3'b100;
      n_checks++;
      if ({level, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL rise_after_abort[%0d]: got lvl/rise/fall=%b expected %b", i, {level, rise, fall}, exp);
      end
    end
    // Reset during CHK_LO with level high must clear level without a fall pulse.
    tick(1'b0);
    tick(1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_chk_lo: got lvl/rise/fall=%b expected 000", {level, rise, fall});
    end
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0);
    n_checks++;
    if ({level, rise, fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_fall_after_reset: got lvl/rise/fall=%b expected 000", {level, rise, fall});
    end
  endtask

  task automatic test_release_high();
    logic [2:0] exp;
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      exp = (i < 3) ? 3'b000 : (i == 3) ? 3'b110 : 3'b100;
      n_checks++;
      if ({level, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL release_high[%0d]: got lvl/rise/fall=%b expected %b", i, {level, rise, fall}, exp);
      end
    end
  endtask

  task automatic test_press_count();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    apply_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      repeat (N) tick(1'b1);
      n_checks++;
      if (rise !== 1'b1) begin
        n_fail++;
        $display("FAIL press_rise[%0d]: got rise=%b expected 1", k, rise);
      end
`ifdef DEBOUNCE_PRESS_COUNT_EN
      n_checks++;
      if (press_count !== PW'(exp_seq[k])) begin
        n_fail++;
        $display("FAIL press_count[%0d]: got %0d expected %0d", k, press_count, exp_seq[k]);
      end
`else
      if (exp_seq[k] < 0) $display("unreachable");
`endif
      repeat (N + 1) tick(1'b0);
    end
  endtask

  task automatic test_random();
    logic v = 1'b0;
    int   run;
    apply_reset(1'b0);
    for (int c = 0; c < 3000;) begin
      v   = ~v;
      run = $urandom_range(1, N + 2);
      for (int j = 0; j < run; j++, c++) begin
        tick(v);
        n_checks++;
        if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
          n_fail++;
          $display("FAIL random[%0d]: got lvl/rise/fall=%b expected %b", c, {level, rise, fall},
                   {m_level, m_rise, m_fall});
        end
        n_checks++;
        if (rise && fall) begin
          n_fail++;
          $display("FAIL random_both_pulses[%0d]: got rise=1 fall=1 expected not both", c);
        end
`ifdef DEBOUNCE_PRESS_COUNT_EN
        n_checks++;
        if (press_count !== PW'(m_presses)) begin
          n_fail++;
          $display("FAIL random_press_count[%0d]: got %0d expected %0d", c, press_count, PW'(m_presses));
        end
`endif
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle_low();
    test_glitch_then_rise();
    test_chatter_fall();
    test_reset_mid_check();
    test_release_high();
    test_press_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
